// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller.
// A Moore FSM that turns load-use hazards into bubbles and taken branches
// into flushes of the front end. It also keeps saturating statistics on how
// many cycles were spent stalling and flushing.
module pipeline_ctrl #(
    parameter int STALL_CYCLES = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iLoadUse,
    input  logic       iBranchTaken,
    output logic       oPCEnable,
    output logic       oIFIDEnable,
    output logic       oBubble,
    output logic       oFlush,
    output logic [1:0] oState,
    output logic [7:0] oStallCount,
    output logic [7:0] oFlushCount
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        STALL   = 2'b01,
        FLUSH   = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    localparam logic [3:0] STALL_LOAD = 4'(STALL_CYCLES);
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t     state;
    state_t     next_state;
    logic [3:0] count;
    logic [3:0] next_count;

    // A branch wins over a load-use in every state. Once an episode has
    // started, load-use requests are ignored until it is over.
    always_comb begin
        next_state = state;
        next_count = count;
        unique case (state)
            RUN: begin
                if (iBranchTaken) begin
                    next_state = FLUSH;
                    next_count = FLUSH_LOAD;
                end else if (iLoadUse) begin
                    next_state = STALL;
                    next_count = STALL_LOAD;
                end
            end
            STALL: begin
                if (iBranchTaken) begin
                    next_state = FLUSH;
                    next_count = FLUSH_LOAD;
                end else if (count == 4'd1) begin
                    next_state = RUN;
                    next_count = 4'd0;
                end else begin
                    next_count = count - 4'd1;
                end
            end
            FLUSH: begin
                if (iBranchTaken) begin
                    next_count = FLUSH_LOAD;
                end else if (count == 4'd1) begin
                    next_state = RUN;
                    next_count = 4'd0;
                end else begin
                    next_count = count - 4'd1;
                end
            end
            default: begin
                next_state = RUN;
                next_count = 4'd0;
            end
        endcase
    end

    // The state register, the episode counter and the control outputs all
    // live here. The outputs are decoded from the state being entered, so
    // they always match the state register and come straight from flops.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= RUN;
            count       <= 4'd0;
            oPCEnable   <= 1'b1;
            oIFIDEnable <= 1'b1;
            oBubble     <= 1'b0;
            oFlush      <= 1'b0;
        end else begin
            state <= next_state;
            count <= next_count;
            unique case (next_state)
                STALL: begin
                    oPCEnable   <= 1'b0;
                    oIFIDEnable <= 1'b0;
                    oBubble     <= 1'b1;
                    oFlush      <= 1'b0;
                end
                FLUSH: begin
                    oPCEnable   <= 1'b1;
                    oIFIDEnable <= 1'b1;
                    oBubble     <= 1'b1;
                    oFlush      <= 1'b1;
                end
                default: begin
                    oPCEnable   <= 1'b1;
                    oIFIDEnable <= 1'b1;
                    oBubble     <= 1'b0;
                    oFlush      <= 1'b0;
                end
            endcase
        end
    end

    // Statistics: each counter counts the edges at which the current state is
    // STALL or FLUSH. The counters stop at 255 instead of wrapping.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            oStallCount <= 8'd0;
            oFlushCount <= 8'd0;
        end else begin
            if (state == STALL && oStallCount != 8'hFF) begin
                oStallCount <= oStallCount + 8'd1;
            end
            if (state == FLUSH && oFlushCount != 8'hFF) begin
                oFlushCount <= oFlushCount + 8'd1;
            end
        end
    end

    assign oState = state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl.
// The stimulus driver updates a behavioural model and queues the expected
// outputs. An independent monitor pops one entry after every rising edge and
// compares it with the DUT.
module tb_pipeline_ctrl;

    localparam int STALL_N = 2;
    localparam int FLUSH_N = 2;

    logic       clock;
    logic       reset;
    logic       load_use;
    logic       branch_taken;
    logic       pc_enable;
    logic       ifid_enable;
    logic       bubble;
    logic       flush;
    logic [1:0] state;
    logic [7:0] stall_count;
    logic [7:0] flush_count;

    int checks = 0;
    int errors = 0;

    // Expected vector: {pc_en, ifid_en, bubble, flush, state[1:0], stall_cnt, flush_cnt}
    logic [21:0] exp_q[$];
    string       label_q[$];

    // Model: cycles still to spend in each kind of episode, plus statistics
    int stall_left = 0;
    int flush_left = 0;
    int stall_stat = 0;
    int flush_stat = 0;

    pipeline_ctrl #(
        .STALL_CYCLES(STALL_N),
        .FLUSH_CYCLES(FLUSH_N)
    ) dut (
        .Clock        (clock),
        .Reset        (reset),
        .iLoadUse     (load_use),
        .iBranchTaken (branch_taken),
        .oPCEnable    (pc_enable),
        .oIFIDEnable  (ifid_enable),
        .oBubble      (bubble),
        .oFlush       (flush),
        .oState       (state),
        .oStallCount  (stall_count),
        .oFlushCount  (flush_count)
    );

    // Free-running clock with a 10-unit period
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Builds the expected outputs from the model's view of which episode is active
    function automatic logic [21:0] expected_outputs();
        logic [5:0] ctl;
        if (flush_left > 0)      ctl = 6'b1111_10;
        else if (stall_left > 0) ctl = 6'b0010_01;
        else                     ctl = 6'b1100_00;
        return {ctl, 8'(stall_stat), 8'(flush_stat)};
    endfunction

    // Drives one cycle of inputs, advances the model across the coming edge
    // and queues what the DUT should show after that edge
    task automatic applyStimulus(input logic rst, input logic lu, input logic br, input string label);
        @(negedge clock);
        reset        = rst;
        load_use     = lu;
        branch_taken = br;
        if (rst) begin
            stall_left = 0;
            flush_left = 0;
            stall_stat = 0;
            flush_stat = 0;
        end else begin
            if (flush_left > 0)                      flush_stat = (flush_stat < 255) ? flush_stat + 1 : 255;
            else if (stall_left > 0)                 stall_stat = (stall_stat < 255) ? stall_stat + 1 : 255;
            if (br) begin
                flush_left = FLUSH_N;
                stall_left = 0;
            end else if (flush_left > 0) begin
                flush_left--;
            end else if (stall_left > 0) begin
                stall_left--;
            end else if (lu) begin
                stall_left = STALL_N;
            end
        end
        exp_q.push_back(expected_outputs());
        label_q.push_back(label);
    endtask

    // Pops one expected entry and compares it with the DUT outputs
    task automatic checkOutput();
        logic [21:0] exp_v;
        logic [21:0] act_v;
        string       label;
        exp_v = exp_q.pop_front();
        label = label_q.pop_front();
        act_v = {pc_enable, ifid_enable, bubble, flush, state, stall_count, flush_count};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got pc=%b ifid=%b bub=%b fl=%b st=%b sc=%0d fc=%0d, expected pc=%b ifid=%b bub=%b fl=%b st=%b sc=%0d fc=%0d",
                     label, act_v[21], act_v[20], act_v[19], act_v[18], act_v[17:16], act_v[15:8], act_v[7:0],
                     exp_v[21], exp_v[20], exp_v[19], exp_v[18], exp_v[17:16], exp_v[15:8], exp_v[7:0]);
        end
    endtask

    // Monitor: samples the DUT shortly after each rising edge
    always @(posedge clock) begin
        #2;
        if (exp_q.size() > 0) checkOutput();
    end

    // Stimulus sequence: directed scenarios first, then random traffic
    initial begin
        reset        = 1'b1;
        load_use     = 1'b0;
        branch_taken = 1'b0;

        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, "reset");

        applyStimulus(1'b0, 1'b1, 1'b0, "load_use");
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, "load_use_drain");

        applyStimulus(1'b1, 1'b0, 1'b0, "reset");
        applyStimulus(1'b0, 1'b0, 1'b1, "branch");
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, "branch_drain");

        applyStimulus(1'b1, 1'b0, 1'b0, "reset");
        applyStimulus(1'b0, 1'b1, 1'b1, "simultaneous");
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, "simultaneous_drain");

        applyStimulus(1'b1, 1'b0, 1'b0, "reset");
        applyStimulus(1'b0, 1'b1, 1'b0, "mid_stall_lu");
        applyStimulus(1'b0, 1'b0, 1'b1, "mid_stall_br");
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, "mid_stall_drain");

        applyStimulus(1'b0, 1'b0, 1'b1, "flush_then_reset_br");
        applyStimulus(1'b1, 1'b1, 1'b1, "reset_mid_flush");
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, "after_reset");

        applyStimulus(1'b0, 1'b1, 1'b0, "stall_then_reset_lu");
        applyStimulus(1'b1, 1'b0, 1'b0, "reset_mid_stall");
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, "after_reset");

        repeat (900) applyStimulus(1'b0, 1'b1, 1'b0, "saturation");
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, "saturation_hold");

        applyStimulus(1'b1, 1'b0, 1'b0, "reset");
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 35),
                          ($urandom_range(0, 99) < 15), "random");
        end

        repeat (2) @(posedge clock);
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left in scoreboard, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
